// File: rtl/accu_group_if.sv
// rtl/accu_group_if.sv - producer/consumer handshake bundle for the group accumulator
interface accu_group_if #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 4
);
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam int OUT_W = DATA_W + $clog2(MAX_N);

  // producer side
  logic [CNT_W-1:0]  cfg_len;
  logic [DATA_W-1:0] data_in;
  logic              valid_a;
  logic              last_a;
  logic              ready_a;

  // consumer side
  logic              valid_b;
  logic              ready_b;
  logic [OUT_W-1:0]  data_out;
  logic [CNT_W-1:0]  count_out;

  // environment view: drives beats and consumer acceptance
  modport master (
    output cfg_len, data_in, valid_a, last_a, ready_b,
    input  ready_a, valid_b, data_out, count_out
  );

  // accumulator view
  modport slave (
    input  cfg_len, data_in, valid_a, last_a, ready_b,
    output ready_a, valid_b, data_out, count_out
  );
endinterface

// File: rtl/accu_group.sv
// rtl/accu_group.sv - sums variable-length groups of input beats, one registered result per group
module accu_group #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 4
) (
  input  logic        clk,
  input  logic        rst,
  accu_group_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam int OUT_W = DATA_W + $clog2(MAX_N);
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_N);

  // group in progress
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  // result register
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             ready_a;
  logic             in_fire;
  logic             out_fire;
  logic             first_beat;
  logic             grp_close;
  logic [CNT_W-1:0] cfg_san;
  logic [CNT_W-1:0] grp_len;
  logic [CNT_W-1:0] cnt_inc;
  logic [OUT_W-1:0] data_ext;
  logic [OUT_W-1:0] sum;

  // A pending result only blocks input if the consumer is not taking it this cycle,
  // which is what allows back-to-back groups without a bubble.
  assign ready_a  = ~valid_q | bus.ready_b;
  assign in_fire  = bus.valid_a & ready_a;
  assign out_fire = valid_q & bus.ready_b;

  // Out-of-range lengths (0 or above MAX_N) fall back to the full group size.
  assign cfg_san    = ((bus.cfg_len == '0) || (bus.cfg_len > MAX_LEN)) ? MAX_LEN : bus.cfg_len;
  assign first_beat = (cnt_q == '0);
  // The first beat of a group must see the freshly sampled length, not the stale len_q.
  assign grp_len    = first_beat ? cfg_san : len_q;
  assign cnt_inc    = cnt_q + 1'b1;
  assign data_ext   = {{(OUT_W-DATA_W){1'b0}}, bus.data_in};
  assign sum        = first_beat ? data_ext : (acc_q + data_ext);
  assign grp_close  = in_fire & ((cnt_inc == grp_len) | bus.last_a);

  // Next-state for the partial group and the result register.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;

    if (in_fire) begin
      acc_d = sum;
      cnt_d = grp_close ? '0 : cnt_inc;
      if (first_beat) begin
        len_d = cfg_san;
      end
    end

    // A close in the same cycle as a consume wins, so valid stays high.
    if (grp_close) begin
      valid_d = 1'b1;
      data_d  = sum;
      count_d = cnt_inc;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that discards any partial group.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= MAX_LEN;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign bus.ready_a   = ready_a;
  assign bus.valid_b   = valid_q;
  assign bus.data_out  = data_q;
  assign bus.count_out = count_q;
endmodule

// File: tb/tb_accu_group.sv
// tb/tb_accu_group.sv - scoreboard bench for accu_group with a queue-based group model
module tb_accu_group;
  localparam int DATA_W = 8;
  localparam int MAX_N  = 4;

  logic clk;
  logic rst;
  int   cyc;

  accu_group_if #(.DATA_W(DATA_W), .MAX_N(MAX_N)) acc_bus ();

  accu_group #(.DATA_W(DATA_W), .MAX_N(MAX_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (acc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int n_vec;
  int n_err;

  // reference model state
  int grp[$];
  int grp_len;
  int exp_sum[$];
  int exp_cnt[$];
  int close_cyc[$];
  int close_sum[$];

  // ready_b policy
  int rb_mode;
  int hold_n;
  bit no_stall;

  // monitor state
  bit prev_hold;
  int prev_data;
  int prev_count;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int san_len(input int c);
    return (c == 0 || c > MAX_N) ? MAX_N : c;
  endfunction

  function automatic bit pick_rb(input int tries);
    case (rb_mode)
      0: return 1'b1;
      1: return ($urandom_range(0, 3) != 0);
      2: return 1'b0;
      default: return (tries >= hold_n);
    endcase
  endfunction

  // Model of an accepted beat: collect beats until the group length or last closes it.
  task automatic model_accept(input int d, input bit lst, input int cfg);
    int s;
    if (grp.size() == 0) grp_len = san_len(cfg);
    grp.push_back(d);
    if (grp.size() == grp_len || lst) begin
      s = 0;
      foreach (grp[i]) s += grp[i];
      exp_sum.push_back(s);
      exp_cnt.push_back(grp.size());
      close_cyc.push_back(cyc + 1);
      close_sum.push_back(s);
      grp.delete();
    end
  endtask

  task automatic beat(input int d, input bit lst, input int cfg);
    int  tries;
    bit  done;
    tries = 0;
    done  = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      acc_bus.valid_a = 1'b1;
      acc_bus.data_in = d[DATA_W-1:0];
      acc_bus.last_a  = lst;
      acc_bus.cfg_len = 3'(cfg);
      acc_bus.ready_b = pick_rb(tries);
      #1;
      if (acc_bus.ready_a) begin
        model_accept(d, lst, cfg);
        done = 1'b1;
        if (no_stall) chk("no_stall", tries, 0);
      end
      tries++;
      if (!done && tries > 100) begin
        chk("beat_accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      acc_bus.valid_a = 1'b0;
      acc_bus.last_a  = ($urandom_range(0, 1) == 1);
      acc_bus.data_in = 8'($urandom);
      acc_bus.cfg_len = 3'($urandom_range(0, 7));
      acc_bus.ready_b = (rb_mode == 3) ? 1'b1 : pick_rb(0);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst             = 1'b1;
    acc_bus.valid_a = 1'b1;
    acc_bus.data_in = 8'd77;
    acc_bus.last_a  = 1'b0;
    acc_bus.ready_b = 1'b0;
    grp.delete();
    exp_sum.delete();
    exp_cnt.delete();
    close_cyc.delete();
    close_sum.delete();
    prev_hold = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_valid_b", int'(acc_bus.valid_b), 0);
      chk("rst_data_out", int'(acc_bus.data_out), 0);
      chk("rst_count_out", int'(acc_bus.count_out), 0);
    end
    rst             = 1'b0;
    acc_bus.valid_a = 1'b0;
    #1;
    chk("rst_ready_a", int'(acc_bus.ready_a), 1);
  endtask

  // Monitor: latency, hold-under-stall, stall gating and in-order result comparison.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (close_cyc.size() > 0 && close_cyc[0] == cyc) begin
          chk("latency_valid_b", int'(acc_bus.valid_b), 1);
          chk("latency_data_out", int'(acc_bus.data_out), close_sum[0]);
          void'(close_cyc.pop_front());
          void'(close_sum.pop_front());
        end
        if (prev_hold) begin
          chk("hold_valid_b", int'(acc_bus.valid_b), 1);
          chk("hold_data_out", int'(acc_bus.data_out), prev_data);
          chk("hold_count_out", int'(acc_bus.count_out), prev_count);
        end
        if (acc_bus.valid_b && !acc_bus.ready_b)
          chk("stall_ready_a", int'(acc_bus.ready_a), 0);
        if (acc_bus.valid_b && acc_bus.ready_b) begin
          if (exp_sum.size() == 0) begin
            chk("unexpected_result", int'(acc_bus.data_out), -1);
          end else begin
            chk("data_out", int'(acc_bus.data_out), exp_sum.pop_front());
            chk("count_out", int'(acc_bus.count_out), exp_cnt.pop_front());
          end
        end
        prev_hold  = acc_bus.valid_b && !acc_bus.ready_b;
        prev_data  = int'(acc_bus.data_out);
        prev_count = int'(acc_bus.count_out);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cyc             = 0;
    n_vec           = 0;
    n_err           = 0;
    rb_mode         = 0;
    hold_n          = 0;
    no_stall        = 1'b0;
    prev_hold       = 1'b0;
    rst             = 1'b1;
    acc_bus.valid_a = 1'b0;
    acc_bus.last_a  = 1'b0;
    acc_bus.data_in = '0;
    acc_bus.cfg_len = '0;
    acc_bus.ready_b = 1'b0;

    // 1: reset held two cycles with valid_a high
    do_reset(2);

    // 2: basic 4-beat group
    rb_mode = 0;
    for (int i = 1; i <= 4; i++) beat(i, 1'b0, 4);
    idle(3);

    // 3: backpressure, then beat 5 accepted on the consuming cycle
    rb_mode = 2;
    for (int i = 1; i <= 4; i++) beat(i, 1'b0, 4);
    rb_mode = 3;
    hold_n  = 4;
    beat(5, 1'b0, 4);
    rb_mode = 0;
    for (int i = 6; i <= 8; i++) beat(i, 1'b0, 4);
    idle(3);

    // 4: early close across gaps, then cfg_len=0 with max data
    beat(200, 1'b0, 4);
    idle(2);
    beat(100, 1'b1, 4);
    idle(2);
    for (int i = 0; i < 4; i++) beat(255, 1'b0, 0);
    idle(3);

    // 5: full throughput, cfg_len toggled on the second beat of each group
    no_stall = 1'b1;
    for (int i = 1; i <= 8; i++) beat(i, 1'b0, (i % 2 == 0) ? 3 : 2);
    no_stall = 1'b0;
    idle(3);

    // 6: reset in the middle of a group
    beat(5, 1'b0, 4);
    beat(6, 1'b0, 4);
    do_reset(1);
    for (int i = 0; i < 4; i++) beat(1, 1'b0, 4);
    idle(3);

    // random traffic with gaps, random lengths, early closes and backpressure
    rb_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      beat(int'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)));
    end
    rb_mode = 0;
    beat(9, 1'b1, 4);
    idle(10);
    chk("drain_pending_results", exp_sum.size(), 0);
    chk("drain_pending_closes", close_cyc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/accu_group.md
Name: accu_group

Overview:
- Parametrised successor to the fixed 4-beat valid/ready accumulator in the arithmetic library.
- Sums a configurable-length group of unsigned input beats and emits one registered sum per group over a valid/ready output handshake.
- Adds a runtime group length, early group close via `last_a`, a beat-count output, and full-throughput back-to-back operation.
- Sits between a streaming producer and a consumer that may apply backpressure.

Parameters:
- DATA_W, 8, width of each input beat (unsigned).
- MAX_N, 4, maximum beats per group; must be ≥2.
- CNT_W, derived localparam = clog2(MAX_N+1), width of the length and count fields.
- OUT_W, derived localparam = DATA_W + clog2(MAX_N), sum width; cannot overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- cfg_len  in  CNT_W  beats per group. Sampled only on the first beat of a group. A value of 0 or >MAX_N is treated as MAX_N.
- data_in  in  DATA_W  input beat.
- valid_a  in  1  input beat valid.
- last_a  in  1  qualified by the input handshake; closes the current group on this beat.
- ready_a  out  1  block can accept a beat.
- valid_b  out  1  data_out/count_out hold a result.
- ready_b  in  1  consumer accepts the result.
- data_out  out  OUT_W  group sum.
- count_out  out  CNT_W  number of beats in the reported group.

Behaviour:
- Reset:
  - Reset is synchronous active-high. Asserting rst at any clock edge, including mid-group or with a pending result, clears the following and discards any partial group: acc=0, cnt=0, len_q=MAX_N, valid_b=0, data_out=0, count_out=0.
  - ready_a=1 from the first cycle after reset.
- Handshakes:
  - ready_a = ~valid_b | ready_b (combinational).
  - An input beat is accepted when valid_a & ready_a. An output is consumed when valid_b & ready_b.
- Accepted beat with cnt==0 (group start):
  - len_q = sanitised cfg_len.
  - acc = data_in.
  - cnt = 1.
- Accepted beat with cnt>0: acc = acc + data_in, cnt = cnt+1.
- Group close:
  - A group closes on the accepted beat where (cnt+1)==len_q, or where last_a=1. For a first beat, compare against the sanitised cfg_len.
  - On close, at the next edge: data_out = acc + data_in (or data_in on the first beat), count_out = beats in the group, valid_b=1, cnt=0.
  - acc need not be cleared on close; the next group start overwrites it.
  - Latency: valid_b rises exactly one cycle after the closing beat is accepted.
- Output hold:
  - valid_b, data_out and count_out stay stable while valid_b & ~ready_b.
  - valid_b falls on consumption unless a new group closes in the same cycle.
  - data_out/count_out keep their last value after consumption until the next close; they are not zeroed.
- Simultaneous consume and close: valid_b stays 1 and data_out/count_out update to the new group. This gives zero bubbles at one group per len_q cycles.
- Stall: while valid_b & ~ready_b, ready_a=0. The partial group in acc/cnt is frozen and no beats are lost.
- valid_a=0 gaps: acc and cnt hold; the group resumes on the next accepted beat.
- cfg_len changes mid-group are ignored until the next group start.
- last_a with valid_a=0, or while ready_a=0, has no effect.
- last_a on a group's first beat produces a 1-beat group: data_out=data_in, count_out=1.
- Arithmetic:
  - Unsigned, zero-extended to OUT_W.
  - The maximum sum MAX_N·(2^DATA_W−1) fits in OUT_W, so no saturation logic is needed.

Test Plan (DATA_W=8, MAX_N=4):
1. Reset: hold rst=1 for 2 cycles with valid_a=1 → valid_b=0, data_out=0, count_out=0, no beat counted. After release, ready_a=1.
2. Basic group: ready_b=1, cfg_len=4, beats 1,2,3,4 on consecutive cycles → valid_b for exactly 1 cycle, one cycle after beat 4, with data_out=10, count_out=4.
3. Backpressure:
   - ready_b=0, beats 1,2,3,4 then data 5 held valid.
   - Expect: valid_b=1, data_out=10 held; ready_a=0; beat 5 not accepted.
   - Raise ready_b → beat 5 accepted that cycle and starts a new group; no beat lost or duplicated.
4. Early close and gaps:
   - cfg_len=4, beats 200, (valid_a=0 for 2 cycles), 100 with last_a=1.
   - Expect: data_out=300, count_out=2.
   - Then cfg_len=0 with beats 255×4 → data_out=1020, count_out=4 (0 treated as MAX_N, no overflow).
5. Throughput: cfg_len=2, ready_b=1, continuous beats 1..8 → results 3,7,11,15 on every second cycle with no stall cycles (ready_a never low). Changing cfg_len to 3 during beat 2 of a group does not alter that group.
6. Mid-operation reset:
   - After accepting 5,6 of a 4-beat group, pulse rst for 1 cycle.
   - Expect: outputs clear to 0.
   - Then beats 1,1,1,1 → data_out=4; no residue from 5,6.
